// File: rtl/reset_sequencer.sv
// Staged reset release: after rst (or a soft restart) all stage resets are held for
// HOLD_CYCLES, then released one at a time, each waiting for its ack or a timeout.
// Define RESET_SEQ_ACK_EN to enable the stage_ack handshake; otherwise every stage
// waits a fixed ACK_TIMEOUT cycles and err_timeout stays 0.
module reset_sequencer #(
    parameter int N_STAGES    = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                soft_rst_req,
    input  logic [N_STAGES-1:0] stage_ack,
    output logic [N_STAGES-1:0] rst_out,
    output logic                seq_busy,
    output logic                seq_done,
    output logic                err_timeout
);

    localparam int CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int K_W     = $clog2(N_STAGES) + 1;

    localparam logic [CNT_W-1:0]    HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [K_W-1:0]      K_LAST       = K_W'(N_STAGES - 1);
    localparam logic [N_STAGES-1:0] STAGE0_MASK  = N_STAGES'(1);
    localparam logic [N_STAGES-1:0] ALL_ONES     = {N_STAGES{1'b1}};

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [K_W-1:0]      k_reg, k_next;
    logic [N_STAGES-1:0] rst_out_reg, rst_out_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;

    // One-hot decode of the stage currently awaiting its ack.
    logic [N_STAGES-1:0] stage_sel;
    genvar gi;
    generate
        for (gi = 0; gi < N_STAGES; gi++) begin : g_sel
            assign stage_sel[gi] = (k_reg == K_W'(gi));
        end
    endgenerate

    logic ack_hit;
    logic timeout_hit;
    logic advance;

`ifdef RESET_SEQ_ACK_EN
    assign ack_hit = |(stage_ack & stage_sel);
`else
    logic unused_stage_ack;
    assign unused_stage_ack = ^stage_ack;
    assign ack_hit          = 1'b0;
`endif

    assign timeout_hit = (cnt_reg == TIMEOUT_LAST);
    assign advance     = ack_hit | timeout_hit;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_ASSERT;
            cnt_reg     <= '0;
            k_reg       <= '0;
            rst_out_reg <= ALL_ONES;
            busy_reg    <= 1'b1;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            k_reg       <= k_next;
            rst_out_reg <= rst_out_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + CNT_W'(1);
        k_next       = k_reg;
        rst_out_next = rst_out_reg;
        busy_next    = busy_reg;
        done_next    = done_reg;
        err_next     = err_reg;

        case (state_reg)
            ST_ASSERT: begin
                if (cnt_reg == HOLD_LAST) begin
                    rst_out_next = rst_out_reg & ~STAGE0_MASK;
                    k_next       = '0;
                    cnt_next     = '0;
                    state_next   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (advance) begin
`ifdef RESET_SEQ_ACK_EN
                    // A simultaneous ack wins over the timeout, so no error then.
                    if (!ack_hit) begin
                        err_next = 1'b1;
                    end
`endif
                    cnt_next = '0;
                    if (k_reg == K_LAST) begin
                        state_next = ST_RUN;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        k_next       = k_reg + K_W'(1);
                        rst_out_next = rst_out_reg & ~(stage_sel << 1);
                    end
                end
            end
            ST_RUN: begin
                cnt_next = cnt_reg;
                if (soft_rst_req) begin
                    rst_out_next = ALL_ONES;
                    done_next    = 1'b0;
                    busy_next    = 1'b1;
                    err_next     = 1'b0;
                    cnt_next     = '0;
                    k_next       = '0;
                    state_next   = ST_ASSERT;
                end
            end
            default: begin
                state_next = ST_ASSERT;
                cnt_next   = '0;
            end
        endcase
    end

    assign rst_out     = rst_out_reg;
    assign seq_busy    = busy_reg;
    assign seq_done    = done_reg;
    assign err_timeout = err_reg;

endmodule
